// File: rtl/alu_pkg.sv
// Shared constants for the ALU execute unit: opcodes, FSM encoding, flag indices.
package alu_pkg;

  localparam logic [3:0] ALU_OP_ADD = 4'd0;
  localparam logic [3:0] ALU_OP_ADC = 4'd1;
  localparam logic [3:0] ALU_OP_SUB = 4'd2;
  localparam logic [3:0] ALU_OP_SBC = 4'd3;
  localparam logic [3:0] ALU_OP_AND = 4'd4;
  localparam logic [3:0] ALU_OP_OR  = 4'd5;
  localparam logic [3:0] ALU_OP_XOR = 4'd6;
  localparam logic [3:0] ALU_OP_NOT = 4'd7;
  localparam logic [3:0] ALU_OP_LSL = 4'd8;
  localparam logic [3:0] ALU_OP_LSR = 4'd9;
  localparam logic [3:0] ALU_OP_ASR = 4'd10;
  localparam logic [3:0] ALU_OP_MOV = 4'd11;
  localparam logic [3:0] ALU_OP_MUL = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  function automatic logic [3:0] mk_flags(
    input logic n, input logic z,
    input logic c, input logic v);
    logic [3:0] f;
    f = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Decode-to-execute op bus with result/flags return path.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic             op_ready;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cf_curr;
  logic             nf_curr;
  logic             zf_curr;
  logic             vf_curr;
  logic [WIDTH-1:0] alu_out;
  logic             alu_ack;
  logic             cf;
  logic             nf;
  logic             zf;
  logic             vf;
  logic             op_illegal;

  modport master (
    output op_valid, op_code, op_a, op_b,
    output cf_curr, nf_curr, zf_curr, vf_curr,
    input  op_ready, alu_out, alu_ack,
    input  cf, nf, zf, vf, op_illegal
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b,
    input  cf_curr, nf_curr, zf_curr, vf_curr,
    output op_ready, alu_out, alu_ack,
    output cf, nf, zf, vf, op_illegal
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier, one multiplier bit per clock; first step runs on start.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;

  // Upper half accumulates, whole register shifts right one bit per step.
  function automatic logic [2*WIDTH-1:0] step(
    input logic [2*WIDTH-1:0] p,
    input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] acc;
    acc = {1'b0, p[2*WIDTH-1:WIDTH]}
        + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {acc, p[WIDTH-1:1]};
  endfunction

  always_comb begin
    prod_d = start_i ? step({{WIDTH{1'b0}}, b_i}, a_i)
                     : step(prod_q, mcand_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start_i) begin
      prod_q  <= prod_d;
      mcand_q <= a_i;
      cnt_q   <= CW'(1);
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q == CW'(WIDTH)) begin
        busy_q <= 1'b0;
      end else begin
        prod_q <= prod_d;
        cnt_q  <= cnt_q + CW'(1);
      end
    end
  end

  assign done_o = busy_q && (cnt_q == CW'(WIDTH));
  assign prod_o = prod_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execute stage; registered result, NZCV flags and ack pulse.
// Define ALU_EXEC_MUL_EN to enable the sequential MUL (opcode 12).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  alu_exec_unit_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [3:0]         flg_q, flg_d;
  logic               ack_q, ack_d;
  logic               ill_q, ill_d;

  logic               xfer, is_mul, legal;
  logic [WIDTH-1:0]   a, b, bop, res;
  logic [WIDTH:0]     sum, sh;
  logic [SHW-1:0]     amt;
  logic               cin, c, v;
  logic [3:0]         alu_f, mul_f;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic               unused_flags;

  assign a   = bus.op_a;
  assign b   = bus.op_b;
  assign amt = b[SHW-1:0];
  assign unused_flags = bus.nf_curr ^ bus.zf_curr;

  assign bus.op_ready = (state_q != ST_BUSY);
  assign xfer = bus.op_valid && bus.op_ready;

`ifdef ALU_EXEC_MUL_EN
  assign is_mul = (bus.op_code == ALU_OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (xfer && is_mul),
    .a_i     (a),
    .b_i     (b),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  assign legal = (bus.op_code <= ALU_OP_MOV) || is_mul;

  // Subtract is a + ~b + carry-in, so C=1 means no borrow.
  always_comb begin
    bop = b;
    cin = 1'b0;
    unique case (bus.op_code)
      ALU_OP_ADC: cin = bus.cf_curr;
      ALU_OP_SUB: begin bop = ~b; cin = 1'b1;        end
      ALU_OP_SBC: begin bop = ~b; cin = bus.cf_curr; end
      default: ;
    endcase
    sum = {1'b0, a} + {1'b0, bop} + {{WIDTH{1'b0}}, cin};
  end

  always_comb begin
    res = '0;
    sh  = '0;
    c   = bus.cf_curr;
    v   = bus.vf_curr;
    unique case (bus.op_code)
      ALU_OP_ADD, ALU_OP_ADC,
      ALU_OP_SUB, ALU_OP_SBC: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == bop[WIDTH-1])
           && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_OP_AND: res = a & b;
      ALU_OP_OR:  res = a | b;
      ALU_OP_XOR: res = a ^ b;
      ALU_OP_NOT: res = ~a;
      ALU_OP_MOV: res = b;
      ALU_OP_LSL: begin
        sh  = {1'b0, a} << amt;
        res = sh[WIDTH-1:0];
        if (amt != '0) c = sh[WIDTH];
      end
      ALU_OP_LSR: begin
        sh  = {a, 1'b0} >> amt;
        res = sh[WIDTH:1];
        if (amt != '0) c = sh[0];
      end
      ALU_OP_ASR: begin
        sh  = $signed({a, 1'b0}) >>> amt;
        res = sh[WIDTH:1];
        if (amt != '0) c = sh[0];
      end
      default: res = '0;
    endcase
  end

  assign alu_f = mk_flags(res[WIDTH-1], res == '0, c, v);
  assign mul_f = mk_flags(mul_prod[WIDTH-1],
                          mul_prod[WIDTH-1:0] == '0,
                          |mul_prod[2*WIDTH-1:WIDTH],
                          |mul_prod[2*WIDTH-1:WIDTH]);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    flg_d   = flg_q;
    ack_d   = 1'b0;
    ill_d   = ill_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (xfer) begin
          if (is_mul) begin
            state_d = ST_BUSY;
          end else begin
            ack_d = 1'b1;
            ill_d = !legal;
            if (legal) begin
              out_d = res;
              flg_d = alu_f;
            end
          end
        end
      end
      ST_BUSY: begin
        if (mul_done) begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
          ill_d   = 1'b0;
          out_d   = mul_prod[WIDTH-1:0];
          flg_d   = mul_f;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      flg_q   <= '0;
      ack_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      flg_q   <= flg_d;
      ack_q   <= ack_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.alu_out    = out_q;
  assign bus.alu_ack    = ack_q;
  assign bus.op_illegal = ill_q;
  assign bus.cf = flg_q[FLAG_C];
  assign bus.nf = flg_q[FLAG_N];
  assign bus.zf = flg_q[FLAG_Z];
  assign bus.vf = flg_q[FLAG_V];

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed vector bench for alu_exec_unit at WIDTH=32.
// Flag vectors are packed {N,Z,C,V}.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(32)) bus();

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       nm;
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        vin;
    logic [31:0] eo;
    logic [3:0]  ef;
    logic        eill;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [3:0] gflags();
    return {bus.nf, bus.zf, bus.cf, bus.vf};
  endfunction

  task automatic drive(input logic [3:0] code,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic cin,
                       input logic vin);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.cf_curr  = cin;
    bus.vf_curr  = vin;
    bus.nf_curr  = 1'b0;
    bus.zf_curr  = 1'b0;
  endtask

  initial begin
    int got_lat;
    int acks;
    logic busy_ok;

    vecs[0]  = '{"add_ovf", ALU_OP_ADD, 32'h7FFFFFFF, 32'h1, 0, 0, 32'h80000000, 4'b1001, 0};
    vecs[1]  = '{"sub_eq",  ALU_OP_SUB, 32'h5, 32'h5, 0, 0, 32'h0, 4'b0110, 0};
    vecs[2]  = '{"and_cv",  ALU_OP_AND, 32'hAAAAAAAA, 32'h55555555, 1, 1, 32'h0, 4'b0111, 0};
    vecs[3]  = '{"lsl1",    ALU_OP_LSL, 32'h80000001, 32'h1, 0, 0, 32'h2, 4'b0010, 0};
    vecs[4]  = '{"asr4",    ALU_OP_ASR, 32'h80000000, 32'h4, 0, 0, 32'hF8000000, 4'b1000, 0};
    vecs[5]  = '{"lsr0",    ALU_OP_LSR, 32'h12345678, 32'h0, 1, 0, 32'h12345678, 4'b0010, 0};
    vecs[6]  = '{"adc",     ALU_OP_ADC, 32'hFFFFFFFF, 32'h0, 1, 0, 32'h0, 4'b0110, 0};
    vecs[7]  = '{"sbc",     ALU_OP_SBC, 32'h5, 32'h3, 0, 0, 32'h1, 4'b0010, 0};
    vecs[8]  = '{"or",      ALU_OP_OR,  32'hF0F0F0F0, 32'h0F0F0F0F, 0, 1, 32'hFFFFFFFF, 4'b1001, 0};
    vecs[9]  = '{"xor",     ALU_OP_XOR, 32'hFFFF0000, 32'hFFFFFFFF, 1, 0, 32'h0000FFFF, 4'b0010, 0};
    vecs[10] = '{"not",     ALU_OP_NOT, 32'h0, 32'h0, 0, 0, 32'hFFFFFFFF, 4'b1000, 0};
    vecs[11] = '{"mov",     ALU_OP_MOV, 32'h0, 32'h80000000, 1, 1, 32'h80000000, 4'b1011, 0};
    vecs[12] = '{"sub_brw", ALU_OP_SUB, 32'h0, 32'h1, 1, 1, 32'hFFFFFFFF, 4'b1000, 0};
    vecs[13] = '{"sub_ovf", ALU_OP_SUB, 32'h80000000, 32'h1, 0, 0, 32'h7FFFFFFF, 4'b0011, 0};
    vecs[14] = '{"lsr31",   ALU_OP_LSR, 32'hC0000000, 32'd31, 0, 0, 32'h1, 4'b0010, 0};
    vecs[15] = '{"ill15",   4'd15, 32'h0, 32'h0, 0, 1, 32'h1, 4'b0010, 1};
    vecs[16] = '{"add_clr", ALU_OP_ADD, 32'h1, 32'h1, 0, 0, 32'h2, 4'b0000, 0};
    vecs[17] = '{"ill13",   4'd13, 32'h5, 32'h6, 1, 1, 32'h2, 4'b0000, 1};
    vecs[18] = '{"asr31",   ALU_OP_ASR, 32'h7FFFFFFF, 32'd31, 0, 0, 32'h0, 4'b0110, 0};
    vecs[19] = '{"lsl31",   ALU_OP_LSL, 32'h1, 32'd31, 1, 0, 32'h80000000, 4'b1000, 0};

    rst = 1'b1;
    drive(4'd0, 32'h0, 32'h0, 0, 0);
    bus.op_valid = 1'b0;
    #1;
    chk("rst_out",   bus.alu_out, 32'h0);
    chk("rst_flags", 32'(gflags()), 32'h0);
    chk("rst_ack",   32'(bus.alu_ack), 32'h0);
    chk("rst_ill",   32'(bus.op_illegal), 32'h0);
    chk("rst_ready", 32'(bus.op_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back: op_valid stays high across consecutive cycles.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].vin);
      @(posedge clk);
      #1;
      chk({vecs[i].nm, "_ack"},   32'(bus.alu_ack), 32'h1);
      chk({vecs[i].nm, "_out"},   bus.alu_out, vecs[i].eo);
      chk({vecs[i].nm, "_flags"}, 32'(gflags()), 32'(vecs[i].ef));
      chk({vecs[i].nm, "_ill"},   32'(bus.op_illegal), 32'(vecs[i].eill));
    end
    @(negedge clk);
    bus.op_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_ack",  32'(bus.alu_ack), 32'h0);
    chk("idle_hold", bus.alu_out, 32'h80000000);

`ifdef ALU_EXEC_MUL_EN
    @(negedge clk);
    drive(ALU_OP_MUL, 32'h00010000, 32'h00010000, 0, 0);
    @(posedge clk);
    #1;
    got_lat = bus.alu_ack ? 1 : 0;
    chk("mul_ready_low", 32'(bus.op_ready), 32'h0);
    drive(ALU_OP_ADD, 32'h1, 32'h1, 0, 0);
    busy_ok = 1'b1;
    for (int n = 2; n <= 40 && got_lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (bus.alu_ack) got_lat = n;
      else if (bus.op_ready) busy_ok = 1'b0;
      if (n == 12) bus.op_valid = 1'b0;
    end
    chk("mul_latency", 32'(got_lat), 32'd33);
    chk("mul_busy",    32'(busy_ok), 32'h1);
    chk("mul_out",     bus.alu_out, 32'h0);
    chk("mul_flags",   32'(gflags()), 32'b0111);
    chk("mul_ill",     32'(bus.op_illegal), 32'h0);
    chk("mul_ready",   32'(bus.op_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("mul_noextra", 32'(bus.alu_ack), 32'h0);
    chk("mul_hold",    bus.alu_out, 32'h0);

    @(negedge clk);
    drive(ALU_OP_MUL, 32'd3, 32'd5, 1, 1);
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    got_lat = 0;
    for (int n = 2; n <= 40 && got_lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (bus.alu_ack) got_lat = n;
    end
    chk("mul2_lat",   32'(got_lat), 32'd33);
    chk("mul2_out",   bus.alu_out, 32'd15);
    chk("mul2_flags", 32'(gflags()), 32'b0000);

    @(negedge clk);
    drive(ALU_OP_MUL, 32'hFFFFFFFF, 32'h2, 0, 0);
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mulrst_out",   bus.alu_out, 32'h0);
    chk("mulrst_ready", 32'(bus.op_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.alu_ack) acks++;
    end
    chk("mulrst_noack", 32'(acks), 32'h0);
`else
    @(negedge clk);
    drive(ALU_OP_MUL, 32'd6, 32'd7, 0, 0);
    @(posedge clk);
    #1;
    chk("mul_off_ack",   32'(bus.alu_ack), 32'h1);
    chk("mul_off_ill",   32'(bus.op_illegal), 32'h1);
    chk("mul_off_out",   bus.alu_out, 32'h80000000);
    chk("mul_off_flags", 32'(gflags()), 32'b1000);
    chk("mul_off_ready", 32'(bus.op_ready), 32'h1);
    @(negedge clk);
    bus.op_valid = 1'b0;
`endif

    @(negedge clk);
    drive(ALU_OP_MOV, 32'h0, 32'hFFFFFFFF, 1, 1);
    @(negedge clk);
    drive(4'd14, 32'h0, 32'h0, 0, 0);
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    chk("pre_rst_ill", 32'(bus.op_illegal), 32'h1);
    chk("pre_rst_out", bus.alu_out, 32'hFFFFFFFF);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out",   bus.alu_out, 32'h0);
    chk("mid_rst_flags", 32'(gflags()), 32'h0);
    chk("mid_rst_ack",   32'(bus.alu_ack), 32'h0);
    chk("mid_rst_ill",   32'(bus.op_illegal), 32'h0);
    chk("mid_rst_ready", 32'(bus.op_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
